// File: rtl/instr_mem_fetch.sv
// instr_mem_fetch
//   Instruction memory for the IF stage. After reset the block sits in BOOT
//   and takes program words from a loader. A load_done pulse moves it to RUN,
//   where it serves one fetch per cycle with one-cycle latency.
//
//   state | meaning
//   ------+--------------------------------------------------------------
//   BOOT  | loader writes accepted, fetch_ready=0
//   RUN   | loads ignored, fetches served; left only through reset
//
// Ports
//   clock, reset_n                  clock, async active-low reset
//   load_en/addr/data, load_done    boot loader write port, BOOT->RUN pulse
//   words_loaded, load_err          accepted-load count (saturating), reject flag
//   fetch_req/addr, fetch_ready     fetch request handshake
//   fetch_valid/data/err            registered fetch result
//   stall, flush                    downstream hold / discard of current result
//   running                         1 in RUN
module instr_mem_fetch #(
  parameter int                    DATA_WIDTH = 32,
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    DEPTH      = 64,
  parameter bit                    BYTE_ADDR  = 1'b1,
  parameter logic [DATA_WIDTH-1:0] NOP_WORD   = '0
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     load_en,
  input  logic [ADDR_WIDTH-1:0]    load_addr,
  input  logic [DATA_WIDTH-1:0]    load_data,
  input  logic                     load_done,
  output logic [$clog2(DEPTH):0]   words_loaded,
  output logic                     load_err,
  input  logic                     fetch_req,
  input  logic [ADDR_WIDTH-1:0]    fetch_addr,
  output logic                     fetch_ready,
  output logic                     fetch_valid,
  output logic [DATA_WIDTH-1:0]    fetch_data,
  output logic                     fetch_err,
  input  logic                     stall,
  input  logic                     flush,
  output logic                     running
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = IDX_W + 1;
  localparam int OFF   = (DATA_WIDTH > 8) ? $clog2(DATA_WIDTH / 8) : 0;
  localparam int SHIFT = BYTE_ADDR ? OFF : 0;
  // Low address bits that must be zero for an aligned byte address.
  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ADDR_WIDTH'((1 << SHIFT) - 1);
  localparam logic [CNT_W-1:0]      FULL       = CNT_W'(DEPTH);

  localparam logic [0:0] BOOT = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;

  logic [0:0]            state;
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic [ADDR_WIDTH-1:0] f_idx_full;
  logic [ADDR_WIDTH-1:0] l_idx_full;
  logic [IDX_W-1:0]      f_idx;
  logic [IDX_W-1:0]      l_idx;
  logic                  f_bad;
  logic                  l_bad;
  logic                  accept;
  logic                  load_ok;

  // Out of range is any set bit above the word index field.
  assign f_idx_full = fetch_addr >> SHIFT;
  assign l_idx_full = load_addr >> SHIFT;
  assign f_idx      = f_idx_full[IDX_W-1:0];
  assign l_idx      = l_idx_full[IDX_W-1:0];
  assign f_bad      = ((fetch_addr & ALIGN_MASK) != '0) || ((f_idx_full >> IDX_W) != '0);
  assign l_bad      = ((load_addr & ALIGN_MASK) != '0) || ((l_idx_full >> IDX_W) != '0);

  assign running     = (state == RUN);
  assign fetch_ready = running & ~stall;
  assign accept      = fetch_req & fetch_ready;
  assign load_ok     = (state == BOOT) & load_en & ~l_bad;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state        <= BOOT;
      words_loaded <= '0;
      load_err     <= 1'b0;
    end else begin
      load_err <= 1'b0;
      if (state == BOOT) begin
        if (load_en) begin
          if (l_bad)
            load_err <= 1'b1;
          else if (words_loaded != FULL)
            words_loaded <= words_loaded + 1'b1;
        end
        // A load in the same cycle as load_done is still taken above.
        if (load_done)
          state <= RUN;
      end
    end
  end

  // Memory is deliberately not reset so a program survives a core reset.
  always_ff @(posedge clock) begin
    if (load_ok)
      mem[l_idx] <= load_data;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      fetch_valid <= 1'b0;
      fetch_data  <= NOP_WORD;
      fetch_err   <= 1'b0;
    end else if (accept) begin
      fetch_valid <= 1'b1;
      fetch_data  <= f_bad ? NOP_WORD : mem[f_idx];
      fetch_err   <= f_bad;
    end else if (flush || !stall) begin
      // Flush beats stall; without a new accept the old result is dropped.
      fetch_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_instr_mem_fetch.sv
module tb_instr_mem_fetch;

  localparam int          DEPTH = 64;
  localparam logic [31:0] NOP   = 32'h0000_0013;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        load_en = 1'b0;
  logic [31:0] load_addr = '0;
  logic [31:0] load_data = '0;
  logic        load_done = 1'b0;
  logic [6:0]  words_loaded;
  logic        load_err;
  logic        fetch_req = 1'b0;
  logic [31:0] fetch_addr = '0;
  logic        fetch_ready;
  logic        fetch_valid;
  logic [31:0] fetch_data;
  logic        fetch_err;
  logic        stall = 1'b0;
  logic        flush = 1'b0;
  logic        running;

  instr_mem_fetch #(
    .DATA_WIDTH(32), .ADDR_WIDTH(32), .DEPTH(DEPTH), .BYTE_ADDR(1'b1), .NOP_WORD(NOP)
  ) dut (
    .clock(clock), .reset_n(reset_n),
    .load_en(load_en), .load_addr(load_addr), .load_data(load_data), .load_done(load_done),
    .words_loaded(words_loaded), .load_err(load_err),
    .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_ready(fetch_ready),
    .fetch_valid(fetch_valid), .fetch_data(fetch_data), .fetch_err(fetch_err),
    .stall(stall), .flush(flush), .running(running)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  // Reference model: what the program memory and the result register should hold.
  logic [31:0] m_mem   [DEPTH];
  bit          m_known [DEPTH];
  bit          m_run   = 0;
  int          m_words = 0;
  bit          m_lerr  = 0;
  bit          m_valid = 0;
  logic [31:0] m_data  = NOP;
  bit          m_err   = 0;
  bit          m_dknown = 1;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit addr_bad(input logic [31:0] a);
    return (a % 4 != 0) || ((a / 4) >= DEPTH);
  endfunction

  task automatic idle();
    load_en = 0; load_done = 0; fetch_req = 0; stall = 0; flush = 0;
  endtask

  // One clock: check handshake, advance the model, compare registered outputs.
  task automatic cycle();
    bit was_run;
    #1;
    chk("ready", fetch_ready, m_run && !stall);
    was_run = m_run;
    if (!m_run) begin
      m_lerr = load_en && addr_bad(load_addr);
      if (load_en && !addr_bad(load_addr)) begin
        m_mem[load_addr / 4]   = load_data;
        m_known[load_addr / 4] = 1;
        if (m_words < DEPTH) m_words++;
      end
      if (load_done) m_run = 1;
    end else begin
      m_lerr = 0;
    end
    if (fetch_req && was_run && !stall) begin
      m_valid = 1;
      m_err   = addr_bad(fetch_addr);
      if (m_err) begin
        m_data = NOP; m_dknown = 1;
      end else begin
        m_data = m_mem[fetch_addr / 4]; m_dknown = m_known[fetch_addr / 4];
      end
    end else if (flush || !stall) begin
      m_valid = 0;
    end
    @(posedge clock);
    #1;
    chk("running", running, m_run);
    chk("words_loaded", words_loaded, m_words);
    chk("load_err", load_err, m_lerr);
    chk("fetch_valid", fetch_valid, m_valid);
    if (m_valid) begin
      chk("fetch_err", fetch_err, m_err);
      if (m_dknown) chk("fetch_data", fetch_data, m_data);
    end
  endtask

  task automatic async_reset(input bit check_data);
    #2;
    reset_n = 0;
    #1;
    m_run = 0; m_words = 0; m_lerr = 0; m_valid = 0; m_err = 0; m_data = NOP;
    chk("rst_valid", fetch_valid, 0);
    chk("rst_running", running, 0);
    chk("rst_words", words_loaded, 0);
    chk("rst_lerr", load_err, 0);
    if (check_data) chk("rst_data", fetch_data, NOP);
    idle();
    #3;
    reset_n = 1;
    @(posedge clock);
    #1;
  endtask

  task automatic do_load(input logic [31:0] a, input logic [31:0] d);
    idle(); load_en = 1; load_addr = a; load_data = d;
    cycle();
  endtask

  task automatic do_fetch(input logic [31:0] a);
    idle(); fetch_req = 1; fetch_addr = a;
    cycle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < DEPTH; i++) m_known[i] = 0;
    idle();
    @(posedge clock);
    #1;
    async_reset(1);

    // Boot load and BOOT-state rejects.
    do_load(0, 32'h1111_1111);
    do_load(4, 32'h2222_2222);
    do_load(8, 32'h3333_3333);
    idle(); fetch_req = 1; fetch_addr = 0;
    cycle();
    chk("boot_no_valid", fetch_valid, 0);
    do_load(32'h102, 32'hdead_beef);
    chk("misaligned_lerr", load_err, 1);
    idle(); cycle();
    chk("lerr_one_cycle", load_err, 0);
    do_load(4 * DEPTH, 32'hbad0_bad0);
    chk("oor_lerr", load_err, 1);
    chk("oor_words", words_loaded, 3);
    idle(); load_done = 1;
    cycle();
    chk("run_entered", running, 1);

    // Back-to-back fetches.
    do_fetch(8);
    chk("tp_f8", fetch_data, 32'h3333_3333);
    do_fetch(0);
    chk("tp_f0", fetch_data, 32'h1111_1111);
    do_fetch(4);
    chk("tp_f4", fetch_data, 32'h2222_2222);
    chk("tp_err", fetch_err, 0);
    do_fetch(4 * DEPTH);
    chk("oor_err", fetch_err, 1);
    chk("oor_nop", fetch_data, NOP);
    do_fetch(6);
    chk("mis_err", fetch_err, 1);
    // Load in RUN must be ignored.
    do_load(0, 32'hffff_ffff);

    // Stall holds the result.
    do_fetch(4);
    idle(); stall = 1;
    for (int i = 0; i < 3; i++) begin
      fetch_req = 1; fetch_addr = 8;
      cycle();
      chk("stall_valid", fetch_valid, 1);
      chk("stall_data", fetch_data, 32'h2222_2222);
    end
    do_fetch(0);
    chk("post_stall", fetch_data, 32'h1111_1111);

    // Flush variants.
    idle(); flush = 1; cycle();
    chk("flush_idle", fetch_valid, 0);
    do_fetch(4);
    idle(); flush = 1; stall = 1; cycle();
    chk("flush_stall", fetch_valid, 0);
    idle(); flush = 1; fetch_req = 1; fetch_addr = 0; cycle();
    chk("flush_accept_v", fetch_valid, 1);
    chk("flush_accept_d", fetch_data, 32'h1111_1111);

    // Reset mid-RUN with a live result; memory must survive.
    do_fetch(8);
    async_reset(1);
    idle(); load_done = 1; cycle();
    do_fetch(0);
    chk("retained", fetch_data, 32'h1111_1111);

    // Randomized phase: fill the whole array, saturate the count, then mix traffic.
    async_reset(1);
    for (int i = 0; i < DEPTH + 8; i++)
      do_load(32'((i % DEPTH) * 4), $urandom);
    chk("words_sat", words_loaded, DEPTH);
    for (int i = 0; i < 40; i++) begin
      idle();
      load_en   = ($urandom_range(0, 3) != 0);
      load_addr = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 4 * DEPTH + 16)
                                              : 32'($urandom_range(0, DEPTH - 1) * 4);
      load_data = $urandom;
      fetch_req = $urandom_range(0, 1);
      fetch_addr = 32'($urandom_range(0, DEPTH - 1) * 4);
      cycle();
    end
    idle(); load_done = 1; cycle();
    for (int i = 0; i < 400; i++) begin
      idle();
      fetch_req  = ($urandom_range(0, 3) != 0);
      fetch_addr = ($urandom_range(0, 4) == 0) ? $urandom_range(0, 4 * DEPTH + 16)
                                               : 32'($urandom_range(0, DEPTH - 1) * 4);
      stall      = ($urandom_range(0, 3) == 0);
      flush      = ($urandom_range(0, 5) == 0);
      load_en    = ($urandom_range(0, 7) == 0);
      load_addr  = 32'($urandom_range(0, DEPTH - 1) * 4);
      load_data  = $urandom;
      load_done  = ($urandom_range(0, 15) == 0);
      cycle();
    end

    idle();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
